// File: rtl/vga_fml_arb.sv
// N-channel FML arbiter: one priority channel, round-robin for the rest, bounded starvation.
// Bursts are granted whole; the slave port is muxed from the single owner while busy.
module vga_fml_arb #(
  parameter int unsigned fml_depth = 20,
  parameter int unsigned NCH       = 3,
  parameter int unsigned BURST     = 4,
  parameter int unsigned PRIO_CH   = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NCH*fml_depth-1:0] m_adr,
  input  logic [NCH-1:0]           m_stb,
  input  logic [NCH-1:0]           m_we,
  input  logic [2*NCH-1:0]         m_sel,
  input  logic [16*NCH-1:0]        m_do,
  output logic [NCH-1:0]           m_ack,
  output logic [15:0]              m_di,
  output logic [fml_depth-1:0]     s_adr,
  output logic                     s_stb,
  output logic                     s_we,
  output logic [1:0]               s_sel,
  output logic [15:0]              s_do,
  input  logic                     s_ack,
  input  logic [15:0]              s_di,
  output logic [NCH-1:0]           grant,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(BURST + 1);
  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StBeat} state_e;

  state_e         state_q;
  logic [NCH-1:0] grant_q;
  logic [IW-1:0]  gidx_q;
  logic [IW-1:0]  ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [SW-1:0]  starv_q;

  logic [NCH-1:0] others;
  logic           prio_win;
  logic           rr_found;
  logic [IW-1:0]  rr_idx;
  logic [IW-1:0]  rr_next;
  logic [IW-1:0]  win_idx;
  logic [CW-1:0]  cnt_load;

  // Round-robin search over non-priority requesters, starting at the pointer.
  always_comb begin
    int unsigned j;
    others          = m_stb;
    others[PRIO_CH] = 1'b0;
    rr_found        = 1'b0;
    rr_idx          = '0;
    j               = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      j = (32'(ptr_q) + k) % NCH;
      if (!rr_found && others[j]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(j);
      end
    end
    rr_next  = IW'((32'(rr_idx) + 1) % NCH);
    prio_win = m_stb[PRIO_CH] &&
               ((MAX_WAIT == 0) || (32'(starv_q) < MAX_WAIT) || (others == '0));
    win_idx  = prio_win ? IW'(PRIO_CH) : rr_idx;
    cnt_load = m_we[gidx_q] ? CW'(BURST - 1) : CW'(BURST);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      starv_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m_stb != '0) begin
            state_q <= StReq;
            grant_q <= {{(NCH-1){1'b0}}, 1'b1} << win_idx;
            gidx_q  <= win_idx;
            if (prio_win) begin
              if (others == '0) begin
                starv_q <= '0;
              end else if (32'(starv_q) < MAX_WAIT) begin
                starv_q <= starv_q + 1'b1;
              end
            end else begin
              starv_q <= '0;
              ptr_q   <= rr_next;
            end
          end
        end
        StReq: begin
          if (s_ack) begin
            cnt_q <= cnt_load;
            if (cnt_load == '0) begin
              state_q <= StIdle;
              grant_q <= '0;
            end else begin
              state_q <= StBeat;
            end
          end
        end
        StBeat: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy  = (state_q != StIdle);
    s_stb = (state_q == StReq);
    grant = grant_q;
    m_ack = (s_stb && s_ack) ? grant_q : '0;
    m_di  = s_di;
    s_adr = '0;
    s_we  = 1'b0;
    s_sel = '0;
    s_do  = '0;
    if (busy) begin
      s_adr = m_adr[gidx_q*fml_depth +: fml_depth];
      s_we  = m_we[gidx_q];
      s_sel = m_sel[gidx_q*2 +: 2];
      s_do  = m_do[gidx_q*16 +: 16];
    end
  end

endmodule

// File: tb/tb_vga_fml_arb.sv
// Directed bench for vga_fml_arb: a MAX_WAIT=4 instance plus a strict-priority
// (MAX_WAIT=0) instance sharing the same master/slave stimulus.
module tb_vga_fml_arb;

  localparam int unsigned W = 20;
  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] m_adr;
  logic [N-1:0]   m_stb, m_we;
  logic [2*N-1:0] m_sel;
  logic [16*N-1:0] m_do;
  logic           s_ack;
  logic [15:0]    s_di;

  logic [N-1:0]   m_ack, grant;
  logic [15:0]    m_di, s_do;
  logic [W-1:0]   s_adr;
  logic           s_stb, s_we, busy;
  logic [1:0]     s_sel;

  logic [N-1:0]   x_m_ack, x_grant;
  logic [15:0]    x_m_di, x_s_do;
  logic [W-1:0]   x_s_adr;
  logic           x_s_stb, x_s_we, x_busy;
  logic [1:0]     x_s_sel;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] gq[$];
  logic [N-1:0] sq[$];
  int strict_ack_bad;

  always #5 clk = ~clk;

  vga_fml_arb #(.fml_depth(W), .NCH(N), .BURST(4), .PRIO_CH(0), .MAX_WAIT(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_do(m_do), .m_ack(m_ack), .m_di(m_di), .s_adr(s_adr), .s_stb(s_stb),
    .s_we(s_we), .s_sel(s_sel), .s_do(s_do), .s_ack(s_ack), .s_di(s_di), .grant(grant),
    .busy(busy)
  );

  vga_fml_arb #(.fml_depth(W), .NCH(N), .BURST(4), .PRIO_CH(0), .MAX_WAIT(0)) dut_strict (
    .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_do(m_do), .m_ack(x_m_ack), .m_di(x_m_di), .s_adr(x_s_adr),
    .s_stb(x_s_stb), .s_we(x_s_we), .s_sel(x_s_sel), .s_do(x_s_do), .s_ack(s_ack),
    .s_di(s_di), .grant(x_grant), .busy(x_busy)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Slave acks in the first REQ cycle; records the owner of every REQ.
  task automatic serve(input int ngr, input int budget);
    int cyc = 0;
    gq.delete();
    sq.delete();
    strict_ack_bad = 0;
    while (gq.size() < ngr && cyc < budget) begin
      @(negedge clk);
      s_ack = s_stb;
      #1;
      if (s_stb) gq.push_back(grant);
      if (x_s_stb) sq.push_back(x_grant);
      if (x_m_ack[2:1] != 2'b00) strict_ack_bad++;
      cyc++;
    end
    checks++;
    if (gq.size() != ngr) begin
      errors++;
      $display("FAIL serve_count: got %0d grants want %0d", gq.size(), ngr);
    end
  endtask

  task automatic drain();
    m_stb = '0;
    for (int i = 0; i < 20 && (busy || x_busy); i++) begin
      @(negedge clk);
      s_ack = s_stb | x_s_stb;
      #1;
    end
    s_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_stb = '0;
    s_ack = 1'b0;
    s_di  = 16'h5a5a;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rst_s_stb: got %b want 0", s_stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b want 000", grant); end
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL rst_m_ack: got %b want 000", m_ack); end
    checks++; if (s_adr !== 20'h0) begin errors++; $display("FAIL rst_s_adr: got %h want 0", s_adr); end
    checks++; if (s_do !== 16'h0) begin errors++; $display("FAIL rst_s_do: got %h want 0", s_do); end
    checks++; if (m_di !== 16'h5a5a) begin errors++; $display("FAIL rst_m_di: got %h want 5a5a", m_di); end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    m_adr[W+:W]   = 20'h01230;
    m_we          = 3'b010;
    m_sel         = 6'b111111;
    m_do[16+:16]  = 16'hD000;
    @(negedge clk);
    m_stb = 3'b010;
    @(negedge clk); #1;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL wr_stb_t1: got %b want 1", s_stb); end
    checks++; if (s_adr !== 20'h01230) begin errors++; $display("FAIL wr_adr: got %h want 01230", s_adr); end
    checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", s_we); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wr_grant: got %b want 010", grant); end
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL wr_ack_early: got %b want 000", m_ack); end
    @(negedge clk); #1;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL wr_stb_t2: got %b want 1", s_stb); end
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL wr_ack: got %b want 010", m_ack); end
    checks++; if (s_do !== 16'hD000) begin errors++; $display("FAIL wr_do0: got %h want d000", s_do); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      s_ack = 1'b0;
      m_stb = '0;
      m_do[16+:16] = 16'hD000 + 16'(i);
      #1;
      checks++;
      if (s_do !== 16'hD000 + 16'(i) || busy !== 1'b1 || s_stb !== 1'b0) begin
        errors++;
        $display("FAIL wr_beat%0d: got do=%h busy=%b stb=%b want do=%h busy=1 stb=0",
                 i, s_do, busy, s_stb, 16'hD000 + 16'(i));
      end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL wr_grant_end: got %b want 000", grant); end
    checks++; if (s_do !== 16'h0) begin errors++; $display("FAIL wr_do_idle: got %h want 0", s_do); end
  endtask

  task automatic test_read();
    m_adr[0+:W] = 20'h00040;
    m_we        = '0;
    @(negedge clk);
    m_stb = 3'b001;
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL rd_stb: got %b want 1", s_stb); end
    checks++; if (m_ack !== 3'b001) begin errors++; $display("FAIL rd_ack: got %b want 001", m_ack); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      s_ack = (i == 2);
      m_stb = '0;
      s_di  = 16'hA000 + 16'(i);
      #1;
      checks++;
      if (m_di !== 16'hA000 + 16'(i) || grant !== 3'b001) begin
        errors++;
        $display("FAIL rd_beat%0d: got di=%h grant=%b want di=%h grant=001",
                 i, m_di, grant, 16'hA000 + 16'(i));
      end
      if (i == 2) begin
        checks++;
        if (m_ack !== 3'b000) begin errors++; $display("FAIL rd_spurious_ack: got %b want 000", m_ack); end
      end
    end
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got %b want 0", busy); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rd_grant_end: got %b want 000", grant); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [4];
    exp_g = '{3'b010, 3'b100, 3'b010, 3'b100};
    do_reset();
    m_stb = 3'b110;
    serve(4, 60);
    drain();
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
        checks++;
        if (gq[i] !== exp_g[i]) begin
          errors++;
          $display("FAIL rr_grant%0d: got %b want %b", i, gq[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int exp_idx [15];
    logic [N-1:0] one;
    exp_idx = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
    one = 3'b001;
    do_reset();
    m_stb = 3'b111;
    serve(15, 200);
    drain();
    for (int i = 0; i < 15; i++) begin
      if (i < gq.size()) begin
        checks++;
        if (gq[i] !== (one << exp_idx[i])) begin
          errors++;
          $display("FAIL starve_grant%0d: got %b want %b", i, gq[i], one << exp_idx[i]);
        end
      end
    end
    checks++;
    if (sq.size() != 15) begin errors++; $display("FAIL strict_count: got %0d want 15", sq.size()); end
    for (int i = 0; i < sq.size(); i++) begin
      checks++;
      if (sq[i] !== 3'b001) begin
        errors++;
        $display("FAIL strict_grant%0d: got %b want 001", i, sq[i]);
      end
    end
    checks++;
    if (strict_ack_bad != 0) begin
      errors++;
      $display("FAIL strict_ack12: got %0d cycles with ack want 0", strict_ack_bad);
    end
  endtask

  task automatic test_reset_mid_burst();
    int found;
    do_reset();
    m_adr[W+:W]   = 20'h00777;
    m_adr[2*W+:W] = 20'h00abc;
    m_we  = 3'b010;
    m_stb = 3'b010;
    @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    m_stb = '0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_stb !== 1'b0 || busy !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: got stb=%b busy=%b grant=%b want 0 0 000", s_stb, busy, grant);
    end
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL mid_spurious: got %b want 000", m_ack); end
    @(negedge clk);
    s_ack = 1'b0;
    m_we  = '0;
    m_stb = 3'b110;
    @(negedge clk); #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL mid_ptr0: got %b want 010", grant); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL mid_ack1: got %b want 010", m_ack); end
    @(negedge clk);
    s_ack = 1'b0;
    m_stb = 3'b100;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      @(negedge clk); #1;
      if (s_stb) found = 1;
    end
    checks++;
    if (found == 0 || grant !== 3'b100 || s_adr !== 20'h00abc) begin
      errors++;
      $display("FAIL mid_ch2: got found=%0d grant=%b adr=%h want 1 100 00abc", found, grant, s_adr);
    end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b100) begin errors++; $display("FAIL mid_ack2: got %b want 100", m_ack); end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr = '0;
    m_stb = '0;
    m_we  = '0;
    m_sel = '0;
    m_do  = '0;
    s_ack = 1'b0;
    s_di  = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_starvation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_fml_arb.md
Name: vga_fml_arb

Overview:
- N-channel FML arbiter merging the VGA FML masters (LCD scan-out, CPU memory bridge, future blitter/overlay) onto one FML slave port toward the SDRAM controller.
- Generalises the fixed two-port VGA arrangement.
  - One display-critical channel gets priority.
  - All other channels share round-robin access.
  - A starvation limit bounds how long the other channels can be locked out.
- Whole bursts are granted atomically.

Parameters:
- fml_depth, 20: FML byte-address width.
- NCH, 3: number of master channels, 2..8.
- BURST, 4: 16-bit beats per FML transaction.
- PRIO_CH, 0: priority channel index (LCD).
- MAX_WAIT, 4: maximum consecutive PRIO_CH grants while another channel is requesting; 0 means strict priority, never overridden.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  synchronous active-low reset.
- m_adr  in  NCH*fml_depth  per-channel address, channel i at [i*fml_depth +: fml_depth].
- m_stb  in  NCH  per-channel request.
- m_we  in  NCH  per-channel write enable.
- m_sel  in  2*NCH  per-channel byte selects.
- m_do  in  16*NCH  per-channel write data.
- m_ack  out  NCH  per-channel acknowledge.
- m_di  out  16  read data, broadcast to all channels.
- s_adr  out  fml_depth  slave address.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_sel  out  2  slave byte selects.
- s_do  out  16  slave write data.
- s_ack  in  1  slave acknowledge.
- s_di  in  16  slave read data.
- grant  out  NCH  one-hot owner, valid while busy.
- busy  out  1  transaction in progress.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low, sampled on the sys_clk rising edge.
  - Reset values: s_stb=0, busy=0, grant=0, m_ack=0, beat counter=0, starvation counter=0, round-robin pointer=0.
  - s_adr, s_we, s_sel and s_do are 0 while not busy.
- FML rules:
  - A master holds stb, adr, we and sel stable until its ack.
  - Write beats: data is presented on the ack cycle plus the next BURST-1 cycles.
  - Read beats: data is valid on cycles ack+1 .. ack+BURST.
- State IDLE:
  - If any m_stb is high, register the winner into grant and go to REQ.
  - The winner is chosen by the arbitration rule below.
- State REQ:
  - s_stb=1; s_adr, s_we and s_sel are muxed from the granted channel.
  - s_do is muxed from the granted channel.
  - m_ack[g] = s_ack, combinational, gated by grant.
  - On s_ack, latch we into the beat counter: BURST-1 for a write, BURST for a read. Go to BEAT, or to IDLE if the count is 0.
- State BEAT:
  - s_stb=0; s_do keeps following the granted channel.
  - The counter decrements each cycle; go to IDLE when it reaches 1.
  - grant is held until IDLE is entered.
- Latency:
  - m_stb rising in IDLE at cycle t gives s_stb=1 at t+1.
  - At least one IDLE cycle separates consecutive transactions.
- Data path:
  - m_di = s_di at all times, unregistered.
  - Each master qualifies read data by its own ack timing.
- Arbitration rule:
  - PRIO_CH wins if it is requesting and the starvation counter is below MAX_WAIT, or MAX_WAIT=0.
  - Otherwise the winner is the first requesting channel ≠ PRIO_CH, searching upward (mod NCH) from the round-robin pointer.
  - If only PRIO_CH is requesting, it wins regardless of the counter.
  - After a non-prio grant, pointer = granted index + 1, mod NCH.
- Starvation counter:
  - Increments on each PRIO_CH grant made while any other m_stb is high.
  - Clears on any non-prio grant.
  - Clears on a PRIO_CH grant with no other request pending.
  - Saturates at MAX_WAIT.
- Boundary cases:
  - s_ack outside REQ is ignored and never reaches any m_ack.
  - Requests that are not granted see m_ack=0 indefinitely.
  - A new request arriving mid-burst waits until the arbiter returns to IDLE.
  - Simultaneous requests resolve in a single cycle.
  - Reset mid-burst aborts immediately: state goes to IDLE and outputs take their reset values; the slave is responsible for its own burst recovery.
  - The pointer wraps NCH-1 → 0, skipping PRIO_CH.
  - NCH=2 degenerates to priority plus starvation relief.

Test Plan:
- Single write on ch1, adr=0x01230, BURST=4, s_ack at t+3:
  - s_stb high t+1..t+3 with s_adr=0x01230 and s_we=1.
  - m_ack[1] pulses at t+3.
  - s_do carries ch1 data for 4 cycles.
  - busy falls after 3 BEAT cycles.
- Read on ch0 with s_di = 0xA001..0xA004 on ack+1..ack+4:
  - m_di matches each beat.
  - grant=001 throughout.
  - IDLE is entered after the 4th beat.
- ch1 and ch2 requesting continuously, ch0 idle:
  - Grants alternate 1,2,1,2.
  - The pointer wraps correctly.
- ch0, ch1 and ch2 all requesting continuously, MAX_WAIT=4:
  - Grant sequence is 0,0,0,0,1,0,0,0,0,2,0,0,0,0,1.
- Same stimulus with MAX_WAIT=0:
  - ch0 is granted forever.
  - m_ack[1] and m_ack[2] never assert.
- sys_rst_n low for 1 cycle mid-BEAT of a write, with a spurious s_ack afterwards:
  - Next cycle: s_stb=0, busy=0, grant=0.
  - A spurious s_ack after reset produces no m_ack.
  - A fresh ch2 request is granted normally, with the pointer starting from 0.
